// File: rtl/xor_accumulator.sv
// xor_accumulator: folds a stream of WIDTH-bit words into a running XOR checksum.
//
// A run starts from IDLE on start (checksum loaded with SEED). In ACCUM each
// handshake (inValid while inReady) XORs inA into the checksum and bumps a
// saturating word counter. The transfer carrying inLast moves to DONE, where
// the result is held with outValid until outAck returns to IDLE.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (priority over everything)
//   start     begin a new run (IDLE only)
//   inA       data word
//   inValid   inA valid this cycle
//   inLast    final word of the run (qualified by inValid)
//   inReady   block accepts a word this cycle (ACCUM)
//   out       checksum register
//   outParity XOR-reduction of out
//   outValid  final result held (DONE)
//   outAck    consumer takes the result
//   count     words accepted in the current/last run (saturating)
//   overflow  sticky: an increment was attempted at the counter maximum
module xor_accumulator #(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     COUNT_WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED       = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       inA,
  input  logic                   inValid,
  input  logic                   inLast,
  output logic                   inReady,
  output logic [WIDTH-1:0]       out,
  output logic                   outParity,
  output logic                   outValid,
  input  logic                   outAck,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          sum_d      = SEED;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        if (inValid) begin
          sum_d = sum_q ^ inA;
          // Counter saturates; the lost increment is recorded in overflow.
          if (count_q == CountMax) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + COUNT_WIDTH'(1);
          end
          if (inLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (outAck) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign inReady   = (state_q == StAccum);
  assign outValid  = (state_q == StDone);
  assign out       = sum_q;
  assign outParity = ^sum_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_xor_accumulator.sv
// Bench for xor_accumulator. Three instances cover the parameter sets needed:
//   0: SEED=0,      COUNT_WIDTH=8   (basic, bubbles, hold, mid-run reset)
//   1: SEED=A5A5,   COUNT_WIDTH=8   (seed load)
//   2: SEED=0,      COUNT_WIDTH=2   (counter saturation / overflow)
// Final results are predicted at stimulus time into per-instance queues and
// checked by a monitor when outValid rises; intermediate state is checked inline.
module tb_xor_accumulator;

  typedef struct {
    logic [15:0] sum;
    logic        par;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        st  [3];
  logic        iv  [3];
  logic        il  [3];
  logic        ack [3];
  logic [15:0] ia  [3];

  logic        rdy_w [3];
  logic [15:0] out_w [3];
  logic        par_w [3];
  logic        val_w [3];
  logic        ovf_w [3];
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_vec  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic vprev [3];

  xor_accumulator #(.WIDTH(16), .COUNT_WIDTH(8), .SEED(16'h0000)) dut0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .inA(ia[0]), .inValid(iv[0]), .inLast(il[0]),
    .inReady(rdy_w[0]), .out(out_w[0]), .outParity(par_w[0]), .outValid(val_w[0]),
    .outAck(ack[0]), .count(cnt0), .overflow(ovf_w[0])
  );

  xor_accumulator #(.WIDTH(16), .COUNT_WIDTH(8), .SEED(16'hA5A5)) dut1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .inA(ia[1]), .inValid(iv[1]), .inLast(il[1]),
    .inReady(rdy_w[1]), .out(out_w[1]), .outParity(par_w[1]), .outValid(val_w[1]),
    .outAck(ack[1]), .count(cnt1), .overflow(ovf_w[1])
  );

  xor_accumulator #(.WIDTH(16), .COUNT_WIDTH(2), .SEED(16'h0000)) dut2 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .inA(ia[2]), .inValid(iv[2]), .inLast(il[2]),
    .inReady(rdy_w[2]), .out(out_w[2]), .outParity(par_w[2]), .outValid(val_w[2]),
    .outAck(ack[2]), .count(cnt2), .overflow(ovf_w[2])
  );

  function automatic logic [7:0] get_cnt(int i);
    if (i == 0) return cnt0;
    if (i == 1) return cnt1;
    return {6'b0, cnt2};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(int i, logic [15:0] sum, logic par, logic [7:0] cnt, logic ovf);
    exp_t e;
    e.sum = sum; e.par = par; e.cnt = cnt; e.ovf = ovf;
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // Monitor: on the first cycle of each held result, pop and compare.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (val_w[i] === 1'b1 && vprev[i] !== 1'b1) begin
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          check($sformatf("dut%0d unexpected result", i), 32'd1, 32'd0);
        end else begin
          if (i == 0) e = q0.pop_front();
          else if (i == 1) e = q1.pop_front();
          else e = q2.pop_front();
          check($sformatf("dut%0d result out", i), 32'(out_w[i]), 32'(e.sum));
          check($sformatf("dut%0d result parity", i), 32'(par_w[i]), 32'(e.par));
          check($sformatf("dut%0d result count", i), 32'(get_cnt(i)), 32'(e.cnt));
          check($sformatf("dut%0d result overflow", i), 32'(ovf_w[i]), 32'(e.ovf));
          check($sformatf("dut%0d result inReady", i), 32'(rdy_w[i]), 32'd0);
        end
      end
      vprev[i] = val_w[i];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic word(int i, logic [15:0] a, logic last);
    iv[i] = 1'b1; ia[i] = a; il[i] = last;
    tick();
    iv[i] = 1'b0; il[i] = 1'b0;
  endtask

  task automatic ack_run(int i);
    ack[i] = 1'b1;
    tick();
    ack[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; iv[i] = 1'b0; il[i] = 1'b0; ack[i] = 1'b0;
      ia[i] = 16'h0; vprev[i] = 1'b0;
    end

    // 1. Reset
    tick(); tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    check("reset out", 32'(out_w[0]), 32'h0);
    check("reset parity", 32'(par_w[0]), 32'd0);
    check("reset outValid", 32'(val_w[0]), 32'd0);
    check("reset inReady", 32'(rdy_w[0]), 32'd0);
    check("reset count", 32'(cnt0), 32'd0);
    check("reset overflow", 32'(ovf_w[0]), 32'd0);

    // 2. Basic run
    start_run(0);
    check("basic inReady", 32'(rdy_w[0]), 32'd1);
    word(0, 16'h00FF, 1'b0);
    check("basic out1", 32'(out_w[0]), 32'h00FF);
    word(0, 16'h0F0F, 1'b0);
    check("basic out2", 32'(out_w[0]), 32'h0FF0);
    check("basic count2", 32'(cnt0), 32'd2);
    push_exp(0, 16'hF00F, 1'b0, 8'd3, 1'b0);
    word(0, 16'hFFFF, 1'b1);
    check("basic outValid", 32'(val_w[0]), 32'd1);
    ack_run(0);
    check("basic idle outValid", 32'(val_w[0]), 32'd0);

    // 3. Bubbles and stray inLast
    start_run(0);
    il[0] = 1'b1;
    tick();
    il[0] = 1'b0;
    tick();
    check("bubble count", 32'(cnt0), 32'd0);
    check("bubble still accum", 32'(rdy_w[0]), 32'd1);
    push_exp(0, 16'h0001, 1'b1, 8'd1, 1'b0);
    word(0, 16'h0001, 1'b1);

    // 4. Result hold
    for (int k = 0; k < 5; k++) begin
      st[0] = k[0]; iv[0] = ~k[0]; ia[0] = 16'hFFFF;
      tick();
      check($sformatf("hold%0d outValid", k), 32'(val_w[0]), 32'd1);
      check($sformatf("hold%0d out", k), 32'(out_w[0]), 32'h0001);
      check($sformatf("hold%0d count", k), 32'(cnt0), 32'd1);
    end
    st[0] = 1'b0; iv[0] = 1'b0;
    ack_run(0);
    check("ack outValid", 32'(val_w[0]), 32'd0);
    check("ack out held", 32'(out_w[0]), 32'h0001);
    check("ack inReady", 32'(rdy_w[0]), 32'd0);

    start_run(1);
    check("seed out", 32'(out_w[1]), 32'hA5A5);
    check("seed inReady", 32'(rdy_w[1]), 32'd1);
    push_exp(1, 16'hAAAA, 1'b0, 8'd1, 1'b0);
    word(1, 16'h0F0F, 1'b1);
    ack_run(1);

    // 5. Mid-run reset
    start_run(0);
    check("restart out", 32'(out_w[0]), 32'h0);
    check("restart count", 32'(cnt0), 32'd0);
    word(0, 16'h1234, 1'b0);
    word(0, 16'h5678, 1'b0);
    check("midrun out", 32'(out_w[0]), 32'h444C);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("midrst out", 32'(out_w[0]), 32'h0);
    check("midrst count", 32'(cnt0), 32'd0);
    check("midrst inReady", 32'(rdy_w[0]), 32'd0);
    iv[0] = 1'b1; ia[0] = 16'hFFFF; il[0] = 1'b1;
    tick(); tick();
    iv[0] = 1'b0; il[0] = 1'b0;
    check("idle ignore out", 32'(out_w[0]), 32'h0);
    check("idle ignore count", 32'(cnt0), 32'd0);
    check("idle ignore outValid", 32'(val_w[0]), 32'd0);

    // 6. Saturation with a 2-bit counter
    start_run(2);
    word(2, 16'h0001, 1'b0);
    word(2, 16'h0002, 1'b0);
    word(2, 16'h0004, 1'b0);
    check("sat count3", 32'({6'b0, cnt2}), 32'd3);
    check("sat no ovf yet", 32'(ovf_w[2]), 32'd0);
    word(2, 16'h0008, 1'b0);
    check("sat count held", 32'({6'b0, cnt2}), 32'd3);
    check("sat ovf set", 32'(ovf_w[2]), 32'd1);
    push_exp(2, 16'h001F, 1'b1, 8'd3, 1'b1);
    word(2, 16'h0010, 1'b1);
    ack_run(2);
    check("sat ovf kept idle", 32'(ovf_w[2]), 32'd1);
    start_run(2);
    check("sat ovf cleared", 32'(ovf_w[2]), 32'd0);
    check("sat count cleared", 32'({6'b0, cnt2}), 32'd0);
    push_exp(2, 16'h0000, 1'b0, 8'd1, 1'b0);
    word(2, 16'h0000, 1'b1);
    ack_run(2);

    tick(); tick();
    check("dut0 results drained", 32'(q0.size()), 32'd0);
    check("dut1 results drained", 32'(q1.size()), 32'd0);
    check("dut2 results drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
